bitnet_phase_ctrl: RTL and testbench
====================================

BITNET_PHASE_CTRL -- requirements
Module: bitnet_phase_ctrl

Interface
REQ-001 Parameter NUM_LAYERS, default 4, SHALL set the number of unit layers sequenced (legal range 1..16).
REQ-002 Parameter SETTLE_CYCLES, default 2, SHALL set the idle cycles after each propagate pulse (legal range 0..15).
REQ-003 clk_in  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_in  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start_in  input  1  SHALL request one sequence run; sampled only in IDLE.
REQ-006 train_in  input  1  SHALL select a training run (forward, backward, update) when high at the accepted start; otherwise forward-only.
REQ-007 abort_in  input  1  SHALL terminate any run in progress.
REQ-008 fd_prop_out  output  NUM_LAYERS  SHALL be the per-layer forward-propagate strobe; bit i drives fd_prop of layer i.
REQ-009 bk_prop_out  output  NUM_LAYERS  SHALL be the per-layer backward-propagate strobe; bit i drives bk_prop of layer i.
REQ-010 oscillator_out  output  1  SHALL drive the oscillator input of all units.
REQ-011 layer_out  output  $clog2(NUM_LAYERS) (min 1)  SHALL report the layer currently being sequenced.
REQ-012 busy_out  output  1  SHALL be high in every state except IDLE.
REQ-013 done_out  output  1  SHALL pulse for one cycle when a run completes normally.

Function
REQ-014 FSM states SHALL be IDLE, FWD, FWD_SETTLE, BWD, BWD_SETTLE, UPDATE, DONE.
REQ-015 IDLE with start_in=1 and abort_in=0 SHALL enter FWD with layer=0 and latch train_in.
REQ-016 FWD SHALL assert only fd_prop_out[layer] for exactly one cycle, then enter FWD_SETTLE (or skip it when SETTLE_CYCLES=0).
REQ-017 FWD_SETTLE SHALL last SETTLE_CYCLES cycles with all strobes low, then: layer<NUM_LAYERS-1 -> layer+1, FWD; last layer with latched train -> layer stays NUM_LAYERS-1, BWD; last layer without -> DONE.
REQ-018 BWD/BWD_SETTLE SHALL mirror FWD/FWD_SETTLE on bk_prop_out with layer decrementing; after layer 0 settles -> UPDATE.
REQ-019 UPDATE SHALL last one cycle; oscillator_out SHALL toggle at the edge leaving UPDATE, then DONE.
REQ-020 DONE SHALL assert done_out for one cycle and return to IDLE; a start_in in the DONE cycle SHALL be ignored.
REQ-021 Start-to-done latency SHALL be N*(1+S)+1 cycles forward-only and 2*N*(1+S)+2 cycles training (N=NUM_LAYERS, S=SETTLE_CYCLES), counted from the cycle start_in is sampled.
REQ-022 At most one bit of fd_prop_out|bk_prop_out SHALL be high in any cycle.
REQ-023 abort_in=1 in any non-IDLE state SHALL enter IDLE next cycle, with strobes low, no done_out pulse and oscillator_out unchanged; abort_in wins over start_in.
REQ-024 start_in while busy_out=1 SHALL be ignored (no queuing); train_in changes mid-run SHALL have no effect.
REQ-025 The layer counter SHALL never wrap; increment/decrement beyond 0..NUM_LAYERS-1 is unreachable.

Reset
REQ-026 rst_in SHALL asynchronously force state IDLE, layer 0, settle counter 0, latched train 0, and all outputs 0 (including oscillator_out); a run in progress is discarded without done_out.

Configuration
REQ-027 With BITNET_TRAIN_EN defined, the block SHALL implement BWD, BWD_SETTLE and UPDATE as specified.
REQ-028 Without BITNET_TRAIN_EN, train_in SHALL be ignored, every run SHALL be forward-only, and bk_prop_out and oscillator_out SHALL be constant 0.

Structure
REQ-029 The FSM state enum (phase_state_t) and the default NUM_LAYERS/SETTLE_CYCLES constants SHALL live in the shared package bitnet_pkg.
REQ-030 The settle countdown SHALL be a sub-module bitnet_settle_timer (load, count-down, expire pulse).

Verification
REQ-031 N=4, S=2, start with train=0 at cycle 0 -> fd_prop_out = 0001/0010/0100/1000 at cycles 1/4/7/10, done_out at 13, bk_prop_out always 0.
REQ-032 N=4, S=2, train=1 -> bk_prop_out = 1000/0100/0010/0001 at cycles 13/16/19/22, oscillator_out 0 -> 1 visible at cycle 26, done_out at 26.
REQ-033 abort_in at cycle 8 of a training run -> IDLE at 9, no strobes, no done_out, oscillator_out unchanged; next start runs normally.
REQ-034 rst_in asserted mid-BWD, asynchronously between edges -> all outputs 0 immediately; start after release gives REQ-031 timing.
REQ-035 N=1, S=0, train=1 -> fd_prop_out=1 at cycle 1, bk_prop_out=1 at 2, UPDATE at 3, done_out at 4; start_in held high throughout busy -> exactly one run.
REQ-036 Build without BITNET_TRAIN_EN, train=1 -> forward-only timing per REQ-031, oscillator_out stays 0.

Source files
------------

// File: rtl/bitnet_pkg.sv
// Shared types and defaults for the BitNet phase controller.
// Holds the phase FSM state enum and default sizing constants.
package bitnet_pkg;

    localparam int DEF_NUM_LAYERS    = 4;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int SETTLE_W          = 4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FWD        = 3'd1,
        FWD_SETTLE = 3'd2,
        BWD        = 3'd3,
        BWD_SETTLE = 3'd4,
        UPDATE     = 3'd5,
        DONE       = 3'd6
    } phase_state_t;

endpackage

// File: rtl/bitnet_settle_timer.sv
// Settle countdown for the phase controller.
// Loads LOAD_VAL, counts down while enabled, flags the final cycle.
module bitnet_settle_timer
    import bitnet_pkg::*;
#(
    parameter int LOAD_VAL = DEF_SETTLE_CYCLES
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic load_in,
    input  logic en_in,
    output logic expire_out
);

    localparam logic [SETTLE_W-1:0] LOAD_V = SETTLE_W'(LOAD_VAL);
    localparam logic [SETTLE_W-1:0] ONE_V  = SETTLE_W'(1);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    // Counter register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reload on request, otherwise count down to zero while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (load_in) begin
            cnt_d = LOAD_V;
        end else if (en_in && cnt_q != '0) begin
            cnt_d = cnt_q - ONE_V;
        end
    end

    // Expire marks the last enabled cycle of the window
    always_comb begin
        expire_out = en_in && (cnt_q == ONE_V);
    end

endmodule

// File: rtl/bitnet_phase_ctrl.sv
// Phase sequencer driving per-layer propagate strobes and oscillator.
// Define BITNET_TRAIN_EN to build backward/update phases.
module bitnet_phase_ctrl
    import bitnet_pkg::*;
#(
    parameter  int NUM_LAYERS    = DEF_NUM_LAYERS,
    parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  train_in,
    input  logic                  abort_in,
    output logic [NUM_LAYERS-1:0] fd_prop_out,
    output logic [NUM_LAYERS-1:0] bk_prop_out,
    output logic                  oscillator_out,
    output logic [LW-1:0]         layer_out,
    output logic                  busy_out,
    output logic                  done_out
);

`ifdef BITNET_TRAIN_EN
    localparam bit TRAIN_EN = 1'b1;
`else
    localparam bit TRAIN_EN = 1'b0;
`endif

    localparam logic [LW-1:0] LAST = LW'(NUM_LAYERS - 1);
    localparam bit            SKIP = (SETTLE_CYCLES == 0);

    phase_state_t  state_q;
    phase_state_t  state_d;
    logic [LW-1:0] layer_q;
    logic [LW-1:0] layer_d;
    logic          train_q;
    logic          train_d;
    logic          osc_q;
    logic          osc_d;

    logic          tmr_load;
    logic          tmr_en;
    logic          tmr_expire;

    bitnet_settle_timer #(
        .LOAD_VAL (SETTLE_CYCLES)
    ) u_settle (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load_in    (tmr_load),
        .en_in      (tmr_en),
        .expire_out (tmr_expire)
    );

    // State register and sequencing flops
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            layer_q <= '0;
            train_q <= 1'b0;
            osc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            train_q <= train_d;
            osc_q   <= osc_d;
        end
    end

    // Next-state: walk layers up, then down when training, abort overrides
    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        train_d  = train_q;
        osc_d    = osc_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in && !abort_in) begin
                    state_d = FWD;
                    layer_d = '0;
                    train_d = train_in & TRAIN_EN;
                end
            end
            FWD, FWD_SETTLE: begin
                if (state_q == FWD && !SKIP) begin
                    state_d  = FWD_SETTLE;
                    tmr_load = 1'b1;
                end else if (state_q == FWD || tmr_expire) begin
                    if (layer_q != LAST) begin
                        state_d = FWD;
                        layer_d = layer_q + 1'b1;
                    end else if (train_q) begin
                        state_d = BWD;
                    end else begin
                        state_d = DONE;
                    end
                end
                tmr_en = (state_q == FWD_SETTLE);
            end
            BWD, BWD_SETTLE: begin
                if (state_q == BWD && !SKIP) begin
                    state_d  = BWD_SETTLE;
                    tmr_load = 1'b1;
                end else if (state_q == BWD || tmr_expire) begin
                    if (layer_q != '0) begin
                        state_d = BWD;
                        layer_d = layer_q - 1'b1;
                    end else begin
                        state_d = UPDATE;
                    end
                end
                tmr_en = (state_q == BWD_SETTLE);
            end
            UPDATE: begin
                state_d = DONE;
                osc_d   = ~osc_q;
            end
            DONE: begin
                state_d = IDLE;
                layer_d = '0;
                train_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                layer_d = '0;
                train_d = 1'b0;
            end
        endcase
        if (abort_in && state_q != IDLE) begin
            state_d  = IDLE;
            layer_d  = '0;
            train_d  = 1'b0;
            osc_d    = osc_q;
            tmr_load = 1'b0;
            tmr_en   = 1'b0;
        end
    end

    // Moore outputs decoded from state and layer
    always_comb begin
        fd_prop_out = '0;
        bk_prop_out = '0;
        if (state_q == FWD) begin
            fd_prop_out[layer_q] = 1'b1;
        end
        if (TRAIN_EN && state_q == BWD) begin
            bk_prop_out[layer_q] = 1'b1;
        end
        oscillator_out = osc_q & TRAIN_EN;
        layer_out      = layer_q;
        busy_out       = (state_q != IDLE);
        done_out       = (state_q == DONE);
    end

endmodule

// File: tb/tb_bitnet_phase_ctrl.sv
// Scoreboard bench for bitnet_phase_ctrl (N=4,S=2 and N=1,S=0).
// Expectations adapt to BITNET_TRAIN_EN.
module tb_bitnet_phase_ctrl;

`ifdef BITNET_TRAIN_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif
    localparam int INF = 32'h7fff_ffff;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start0, train0, abort0;
    logic [3:0] fd0, bk0;
    logic       osc0, busy0, done0;
    logic [1:0] layer0;

    logic       start1, train1, abort1;
    logic [0:0] fd1, bk1;
    logic       osc1, busy1, done1;
    logic [0:0] layer1;

    bitnet_phase_ctrl #(.NUM_LAYERS(4), .SETTLE_CYCLES(2)) u_dut (
        .clk_in(clk), .rst_in(rst), .start_in(start0), .train_in(train0),
        .abort_in(abort0), .fd_prop_out(fd0), .bk_prop_out(bk0),
        .oscillator_out(osc0), .layer_out(layer0), .busy_out(busy0),
        .done_out(done0)
    );

    bitnet_phase_ctrl #(.NUM_LAYERS(1), .SETTLE_CYCLES(0)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start1), .train_in(train1),
        .abort_in(abort1), .fd_prop_out(fd1), .bk_prop_out(bk1),
        .oscillator_out(osc1), .layer_out(layer1), .busy_out(busy1),
        .done_out(done1)
    );

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    ev_t  q0[$];
    ev_t  q1[$];
    logic exp_osc0 = 1'b0;
    logic exp_osc1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        int guard = 0;
        while (cyc < t && guard < 2000) begin
            tick;
            guard++;
        end
    endtask

    task automatic push_run0(input int c, input bit req_train, input int stop);
        bit         t;
        int         cy;
        logic [3:0] s;
        logic       o;
        t = req_train & TR;
        o = exp_osc0;
        for (int i = 0; i < 4; i++) begin
            cy = c + 1 + 3 * i;
            s  = 4'(1 << i);
            if (cy < stop) q0.push_back('{cy, {6'd0, o, 1'b0, 4'd0, s}});
        end
        if (t) begin
            for (int j = 0; j < 4; j++) begin
                cy = c + 13 + 3 * j;
                s  = 4'(8 >> j);
                if (cy < stop) q0.push_back('{cy, {6'd0, o, 1'b0, s, 4'd0}});
            end
        end
        cy = t ? c + 26 : c + 13;
        if (cy < stop) begin
            if (t) o = ~o;
            q0.push_back('{cy, {6'd0, o, 1'b1, 8'd0}});
            exp_osc0 = o;
        end
    endtask

    task automatic push_run1(input int c, input bit req_train);
        bit t;
        t = req_train & TR;
        q1.push_back('{c + 1, 16'h0001});
        if (t) begin
            q1.push_back('{c + 2, 16'h0002});
            q1.push_back('{c + 4, 16'h000c});
            exp_osc1 = 1'b1;
        end else begin
            q1.push_back('{c + 2, {12'd0, exp_osc1, 3'b100}});
        end
    endtask

    // Strobe/done monitor for the 4-layer instance
    always @(negedge clk) begin : mon0
        logic [15:0] obs;
        ev_t         e;
        obs = {6'd0, osc0, done0, bk0, fd0};
        while (q0.size() > 0 && q0[0].cyc < cyc) begin
            check_eq("missed0", cyc, q0[0].cyc);
            void'(q0.pop_front());
        end
        if (|{fd0, bk0, done0}) begin
            check_eq("onehot0", int'($countones({fd0, bk0}) <= 1), 1);
            if (q0.size() == 0 || q0[0].cyc != cyc) begin
                check_eq("unexp0", int'(obs), 0);
            end else begin
                e = q0.pop_front();
                check_eq("ev0", int'(obs), int'(e.val));
            end
        end
    end

    // Strobe/done monitor for the 1-layer instance
    always @(negedge clk) begin : mon1
        logic [15:0] obs;
        ev_t         e;
        obs = {12'd0, osc1, done1, bk1, fd1};
        while (q1.size() > 0 && q1[0].cyc < cyc) begin
            check_eq("missed1", cyc, q1[0].cyc);
            void'(q1.pop_front());
        end
        if (|{fd1, bk1, done1}) begin
            if (q1.size() == 0 || q1[0].cyc != cyc) begin
                check_eq("unexp1", int'(obs), 0);
            end else begin
                e = q1.pop_front();
                check_eq("ev1", int'(obs), int'(e.val));
            end
        end
    end

    initial begin
        int c;
        int len;
        rst = 1'b1;
        start0 = 1'b0; train0 = 1'b0; abort0 = 1'b0;
        start1 = 1'b0; train1 = 1'b0; abort1 = 1'b0;
        tick;
        tick;
        check_eq("rst_fd", int'(fd0), 0);
        check_eq("rst_bk", int'(bk0), 0);
        check_eq("rst_osc", int'(osc0), 0);
        check_eq("rst_busy", int'(busy0), 0);
        check_eq("rst_done", int'(done0), 0);
        check_eq("rst_layer", int'(layer0), 0);
        rst = 1'b0;
        tick;

        // forward run, with ignored starts mid-run and in DONE
        c = cyc;
        start0 = 1'b1; train0 = 1'b0;
        push_run0(c, 1'b0, INF);
        tick;
        start0 = 1'b0;
        check_eq("fwd_busy", int'(busy0), 1);
        check_eq("fwd_layer0", int'(layer0), 0);
        wait_to(c + 5);
        start0 = 1'b1; train0 = 1'b1;
        tick;
        start0 = 1'b0;
        wait_to(c + 7);
        check_eq("fwd_layer2", int'(layer0), 2);
        wait_to(c + 13);
        start0 = 1'b1;
        tick;
        start0 = 1'b0; train0 = 1'b0;
        check_eq("done_start_ign", int'(busy0), 0);
        tick;
        check_eq("idle_after", int'(busy0), 0);

        // training run, train_in dropped mid-run
        c = cyc;
        start0 = 1'b1; train0 = 1'b1;
        push_run0(c, 1'b1, INF);
        tick;
        start0 = 1'b0; train0 = 1'b0;
        wait_to(c + 20);
        check_eq("trn_busy20", int'(busy0), int'(TR));
        wait_to(c + 25);
        check_eq("upd_osc_old", int'(osc0), 0);
        check_eq("upd_strobes", int'({fd0, bk0}), 0);
        wait_to(c + 27);
        check_eq("trn_idle", int'(busy0), 0);
        check_eq("trn_osc", int'(osc0), int'(exp_osc0));

        // abort wins over start in IDLE
        start0 = 1'b1; abort0 = 1'b1;
        tick;
        start0 = 1'b0; abort0 = 1'b0;
        check_eq("abort_vs_start", int'(busy0), 0);

        // abort at cycle 8 of a training run
        c = cyc;
        start0 = 1'b1; train0 = 1'b1;
        push_run0(c, 1'b1, c + 9);
        tick;
        start0 = 1'b0; train0 = 1'b0;
        wait_to(c + 8);
        abort0 = 1'b1;
        tick;
        abort0 = 1'b0;
        check_eq("abort_busy", int'(busy0), 0);
        check_eq("abort_done", int'(done0), 0);
        check_eq("abort_fd", int'(fd0), 0);
        check_eq("abort_osc", int'(osc0), int'(exp_osc0));
        wait_to(c + 30);
        check_eq("abort_stays", int'(busy0), 0);
        c = cyc;
        start0 = 1'b1;
        push_run0(c, 1'b0, INF);
        tick;
        start0 = 1'b0;
        wait_to(c + 15);
        check_eq("post_abort_idle", int'(busy0), 0);

        // asynchronous reset mid-backward
        c = cyc;
        start0 = 1'b1; train0 = 1'b1;
        push_run0(c, 1'b1, INF);
        tick;
        start0 = 1'b0; train0 = 1'b0;
        wait_to(c + 14);
        #2;
        rst = 1'b1;
        q0.delete();
        exp_osc0 = 1'b0;
        #1;
        check_eq("arst_fd", int'(fd0), 0);
        check_eq("arst_bk", int'(bk0), 0);
        check_eq("arst_osc", int'(osc0), 0);
        check_eq("arst_busy", int'(busy0), 0);
        check_eq("arst_layer", int'(layer0), 0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        c = cyc;
        start0 = 1'b1;
        push_run0(c, 1'b0, INF);
        tick;
        start0 = 1'b0;
        wait_to(c + 15);
        check_eq("post_rst_idle", int'(busy0), 0);

        // single layer, no settle, start held through the run
        c = cyc;
        len = TR ? 4 : 2;
        start1 = 1'b1; train1 = 1'b1;
        push_run1(c, 1'b1);
        wait_to(c + len + 1);
        start1 = 1'b0; train1 = 1'b0;
        check_eq("n1_idle", int'(busy1), 0);
        check_eq("n1_osc", int'(osc1), int'(exp_osc1));
        wait_to(c + len + 10);
        check_eq("n1_one_run", int'(busy1), 0);

        wait_to(cyc + 3);
        check_eq("q0_empty", q0.size(), 0);
        check_eq("q1_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
